// File: rtl/bp_fe_scan_block.sv
// Fetch-block scanner: walks a block of 16-bit parcels, classifies the first
// control-flow instruction and carries a 32-bit instruction across blocks.

module bp_fe_scan_decode #(
  parameter bit compressed_p = 1'b1
) (
  input  logic [15:0] lo_i,
  input  logic [3:0]  hi_i,   // only the rs1 bits of the upper parcel matter
  output logic        is32_o,
  output logic [4:0]  cls_o   // {branch, jal, jalr, call, return}
);
  logic [6:0] opc;
  logic [4:0] rd, rs1, crs2;
  logic [2:0] f3;
  logic       link_rd, link_rs1;
  logic       br32, jal32, jalr32, cj, cb, cjr, cjalr;
  logic [4:0] cls32, cls16;

  assign is32_o   = (lo_i[1:0] == 2'b11) || !compressed_p;
  assign opc      = lo_i[6:0];
  assign rd       = lo_i[11:7];
  assign rs1      = {hi_i, lo_i[15]};
  assign crs2     = lo_i[6:2];
  assign f3       = lo_i[15:13];
  assign link_rd  = (rd == 5'd1) || (rd == 5'd5);
  assign link_rs1 = (rs1 == 5'd1) || (rs1 == 5'd5);

  assign br32   = (opc == 7'b1100011);
  assign jal32  = (opc == 7'b1101111);
  assign jalr32 = (opc == 7'b1100111);
  assign cls32  = {br32, jal32, jalr32, (jal32 | jalr32) & link_rd,
                   jalr32 & link_rs1 & ~(link_rd & (rd == rs1))};

  // RVC: the register field at [11:7] is rs1 for C.JR/C.JALR
  assign cj    = (lo_i[1:0] == 2'b01) && (f3 == 3'b101);
  assign cb    = (lo_i[1:0] == 2'b01) && (f3[2:1] == 2'b11);
  assign cjr   = (lo_i[1:0] == 2'b10) && (f3 == 3'b100) && !lo_i[12]
                 && (rd != 5'd0) && (crs2 == 5'd0);
  assign cjalr = (lo_i[1:0] == 2'b10) && (f3 == 3'b100) && lo_i[12]
                 && (rd != 5'd0) && (crs2 == 5'd0);
  assign cls16 = {cb, cj, cjr | cjalr, cjalr,
                  (cjr & link_rd) | (cjalr & link_rd & (rd != 5'd1))};

  assign cls_o = is32_o ? cls32 : cls16;
endmodule

module bp_fe_scan_block #(
  parameter int fetch_parcels_p      = 4,
  parameter bit compressed_support_p = 1'b1,
  parameter int vaddr_width_p        = 39,
  localparam int IdxW = $clog2(fetch_parcels_p)
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          redirect_i,
  input  logic                          fetch_v_i,
  output logic                          fetch_ready_o,
  input  logic [vaddr_width_p-1:0]      fetch_pc_i,
  input  logic [16*fetch_parcels_p-1:0] fetch_data_i,
  output logic                          scan_v_o,
  input  logic                          scan_yumi_i,
  output logic                          br_v_o,
  output logic                          branch_o,
  output logic                          jal_o,
  output logic                          jalr_o,
  output logic                          call_o,
  output logic                          return_o,
  output logic [IdxW-1:0]               br_idx_o,
  output logic                          br_straddle_o,
  output logic [vaddr_width_p-1:0]      br_pc_o,
  output logic                          partial_o
);
  localparam int N = fetch_parcels_p;

  typedef struct packed {
    logic                     br_v;
    logic [4:0]               cls;
    logic [IdxW-1:0]          idx;
    logic                     strad;
    logic [vaddr_width_p-1:0] pc;
    logic                     partial;
  } res_t;

  logic [N-1:0][15:0] parcel;
  logic [N-1:0][3:0]  hi_nib;
  logic [N-1:0]       is32;
  logic [N-1:0][4:0]  cls;
  logic               strad_is32;
  logic [4:0]         strad_cls;

  logic               scan_v_q, partial_q;
  logic [15:0]        partial_lo_q;
  res_t               res_d, res_q;
  logic               walk_start, accept;

  assign parcel = fetch_data_i;

  for (genvar k = 0; k < N; k++) begin : g_lane
    if (k < N-1) begin : g_hi
      assign hi_nib[k] = parcel[k+1][3:0];
    end else begin : g_last
      assign hi_nib[k] = 4'b0;
    end
    bp_fe_scan_decode #(.compressed_p(compressed_support_p)) u_dec (
      .lo_i   (parcel[k]),
      .hi_i   (hi_nib[k]),
      .is32_o (is32[k]),
      .cls_o  (cls[k])
    );
  end

  bp_fe_scan_decode #(.compressed_p(compressed_support_p)) u_strad_dec (
    .lo_i   (partial_lo_q),
    .hi_i   (parcel[0][3:0]),
    .is32_o (strad_is32),
    .cls_o  (strad_cls)
  );

  assign fetch_ready_o = ~redirect_i & (~scan_v_q | scan_yumi_i);
  assign accept        = fetch_v_i & fetch_ready_o;

  // walk_start marks parcels that begin an instruction; the carried-in upper
  // half at parcel 0 is consumed by the straddle decoder instead.
  always_comb begin
    res_d      = '0;
    walk_start = ~partial_q;
    if (partial_q && strad_is32 && (|strad_cls)) begin
      res_d.br_v  = 1'b1;
      res_d.cls   = strad_cls;
      res_d.strad = 1'b1;
    end
    for (int k = 0; k < N; k++) begin
      if (walk_start) begin
        if (is32[k] && (k == N-1)) begin
          res_d.partial = compressed_support_p;
        end else if (!res_d.br_v && (|cls[k])) begin
          res_d.br_v = 1'b1;
          res_d.cls  = cls[k];
          res_d.idx  = IdxW'(k);
        end
        walk_start = ~is32[k];
      end else begin
        walk_start = 1'b1;
      end
    end
    res_d.pc = res_d.strad ? fetch_pc_i - vaddr_width_p'(2)
                           : fetch_pc_i + (vaddr_width_p'(res_d.idx) << 1);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      scan_v_q     <= 1'b0;
      partial_q    <= 1'b0;
      partial_lo_q <= '0;
      res_q        <= '0;
    end else if (redirect_i) begin
      scan_v_q  <= 1'b0;
      partial_q <= 1'b0;
    end else if (accept) begin
      scan_v_q     <= 1'b1;
      partial_q    <= res_d.partial;
      partial_lo_q <= parcel[N-1];
      res_q        <= res_d;
    end else if (scan_yumi_i) begin
      scan_v_q <= 1'b0;
    end
  end

  assign scan_v_o      = scan_v_q;
  assign br_v_o        = res_q.br_v;
  assign branch_o      = res_q.cls[4];
  assign jal_o         = res_q.cls[3];
  assign jalr_o        = res_q.cls[2];
  assign call_o        = res_q.cls[1];
  assign return_o      = res_q.cls[0];
  assign br_idx_o      = res_q.idx;
  assign br_straddle_o = res_q.strad;
  assign br_pc_o       = res_q.pc;
  assign partial_o     = res_q.partial;
endmodule

// File: tb/tb_bp_fe_scan_block.sv
// Bench for bp_fe_scan_block: directed scenarios plus randomized traffic
// compared against a block-level reference model.

module tb_bp_fe_scan_block;
  localparam int NP = 4;
  localparam int VW = 39;

  logic          clk = 1'b0;
  logic          reset_i, redirect_i, fetch_v_i, scan_yumi_i;
  logic [VW-1:0] fetch_pc_i;
  logic [63:0]   fetch_data_i;
  logic          fetch_ready_o, scan_v_o, br_v_o, branch_o, jal_o, jalr_o, call_o, return_o;
  logic [1:0]    br_idx_o;
  logic          br_straddle_o, partial_o;
  logic [VW-1:0] br_pc_o;

  always #5 clk = ~clk;

  bp_fe_scan_block #(.fetch_parcels_p(NP), .compressed_support_p(1'b1), .vaddr_width_p(VW)) dut (
    .clk_i(clk), .reset_i(reset_i), .redirect_i(redirect_i), .fetch_v_i(fetch_v_i),
    .fetch_ready_o(fetch_ready_o), .fetch_pc_i(fetch_pc_i), .fetch_data_i(fetch_data_i),
    .scan_v_o(scan_v_o), .scan_yumi_i(scan_yumi_i), .br_v_o(br_v_o), .branch_o(branch_o),
    .jal_o(jal_o), .jalr_o(jalr_o), .call_o(call_o), .return_o(return_o), .br_idx_o(br_idx_o),
    .br_straddle_o(br_straddle_o), .br_pc_o(br_pc_o), .partial_o(partial_o)
  );

  typedef struct packed {
    logic          br_v;
    logic [4:0]    cls;   // {branch, jal, jalr, call, return}
    logic [1:0]    idx;
    logic          strad;
    logic [VW-1:0] pc;
    logic          partial;
  } exp_t;

  exp_t dut_r;
  assign dut_r = {br_v_o, branch_o, jal_o, jalr_o, call_o, return_o,
                  br_idx_o, br_straddle_o, br_pc_o, partial_o};

  int          n_tests = 0, n_fail = 0;
  bit          m_v = 1'b0, m_pend = 1'b0;
  logic [15:0] m_lo = 16'h0;
  exp_t        m_res = '0;
  bit          rdy_d, rdy_e;

  function automatic bit lnk(input int r);
    return (r == 1) || (r == 5);
  endfunction

  // Identify the mnemonic, then apply the link-register rules; C.JR and C.JALR
  // are treated as JALR with implied rd of x0 and x1.
  function automatic logic [4:0] classify(input logic [31:0] ins);
    int m, rd, rs1;
    bit br, jal, jalr, call, ret;
    m = 0; rd = 0; rs1 = 0; br = 0; jal = 0; jalr = 0; call = 0; ret = 0;
    if (ins[1:0] == 2'b11) begin
      rd  = int'(ins[11:7]);
      rs1 = int'(ins[19:15]);
      if (ins[6:0] == 7'h63) m = 1;
      else if (ins[6:0] == 7'h6F) m = 2;
      else if (ins[6:0] == 7'h67) m = 3;
    end else begin
      rs1 = int'(ins[11:7]);
      if (ins[1:0] == 2'b01 && ins[15:13] == 3'b101) m = 4;
      else if (ins[1:0] == 2'b01 && ins[15:14] == 2'b11) m = 5;
      else if (ins[1:0] == 2'b10 && ins[15:13] == 3'b100 && ins[6:2] == 5'd0 && rs1 != 0) begin
        m  = ins[12] ? 7 : 6;
        rd = ins[12] ? 1 : 0;
      end
    end
    case (m)
      1, 5:    br = 1;
      2:       begin jal = 1; call = lnk(rd); end
      4:       jal = 1;
      3, 6, 7: begin jalr = 1; call = lnk(rd); ret = lnk(rs1) && !(lnk(rd) && rd == rs1); end
      default: ;
    endcase
    return {br, jal, jalr, call, ret};
  endfunction

  function automatic exp_t scan_model(input logic [VW-1:0] pc, input logic [63:0] data,
                                      input bit pend, input logic [15:0] plo,
                                      output bit npend, output logic [15:0] nlo);
    exp_t r; int pos; logic [15:0] p; logic [4:0] c;
    r = '0; npend = 0; nlo = 16'h0; pos = 0;
    if (pend) begin
      c = classify({data[15:0], plo});
      if (c != 0) begin r.br_v = 1; r.cls = c; r.strad = 1; r.pc = pc - VW'(2); end
      pos = 1;
    end
    while (pos < NP) begin
      p = data[16*pos +: 16];
      if (p[1:0] == 2'b11 && pos == NP-1) begin
        npend = 1; nlo = p; r.partial = 1; pos = NP;
      end else begin
        if (p[1:0] == 2'b11) c = classify({data[16*(pos+1) +: 16], p});
        else                 c = classify({16'h0, p});
        if (!r.br_v && c != 0) begin
          r.br_v = 1; r.cls = c; r.idx = 2'(pos); r.pc = pc + VW'(2*pos);
        end
        pos += (p[1:0] == 2'b11) ? 2 : 1;
      end
    end
    return r;
  endfunction

  // Index, straddle and PC are only meaningful when a control-flow op was found.
  function automatic exp_t msk(input exp_t x, input bit bv);
    exp_t y = x;
    if (!bv) begin y.idx = '0; y.strad = 1'b0; y.pc = '0; end
    return y;
  endfunction

  task automatic cycle(input bit fv, input logic [VW-1:0] pc, input logic [63:0] data,
                       input bit yumi, input bit redir, output bit rd_dut, output bit rd_exp);
    bit np; logic [15:0] nl;
    fetch_v_i = fv; fetch_pc_i = pc; fetch_data_i = data; scan_yumi_i = yumi; redirect_i = redir;
    #1 rd_dut = fetch_ready_o;
    rd_exp = !redir && (!m_v || yumi);
    if (redir) begin
      m_v = 0; m_pend = 0;
    end else if (fv && rd_exp) begin
      m_res = scan_model(pc, data, m_pend, m_lo, np, nl);
      m_pend = np; m_lo = nl; m_v = 1;
    end else if (yumi) begin
      m_v = 0;
    end
    @(posedge clk); #1;
    fetch_v_i = 0; scan_yumi_i = 0; redirect_i = 0;
  endtask

  task automatic test_reset;
    reset_i = 1; redirect_i = 0; fetch_v_i = 0; scan_yumi_i = 0; fetch_pc_i = '0; fetch_data_i = '0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++; if (scan_v_o !== 1'b0) begin n_fail++; $display("FAIL reset_scan_v got=%b exp=0", scan_v_o); end
    n_tests++; if (dut_r !== exp_t'(0)) begin n_fail++; $display("FAIL reset_outputs got=%h exp=0", dut_r); end
    n_tests++; if (fetch_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", fetch_ready_o); end
    reset_i = 0; m_v = 0; m_pend = 0;
  endtask

  task automatic test_jal;
    exp_t e = '0;
    cycle(1, 39'h80000000, 64'h0001_0001_A001_0001, m_v, 0, rdy_d, rdy_e);
    e.br_v = 1; e.cls = 5'b01000; e.idx = 2'd1; e.pc = 39'h80000002;
    n_tests++; if (scan_v_o !== 1'b1) begin n_fail++; $display("FAIL jal_scan_v got=%b exp=1", scan_v_o); end
    n_tests++; if (dut_r !== e) begin n_fail++; $display("FAIL jal_result got=%h exp=%h", dut_r, e); end
  endtask

  task automatic test_first_wins;
    exp_t e = '0;
    cycle(1, 39'h2000, 64'h0001_8082_0000_00EF, m_v, 0, rdy_d, rdy_e);
    e.br_v = 1; e.cls = 5'b01010; e.idx = 2'd0; e.pc = 39'h2000;
    n_tests++; if (rdy_d !== 1'b1) begin n_fail++; $display("FAIL first_wins_ready got=%b exp=1", rdy_d); end
    n_tests++; if (dut_r !== e) begin n_fail++; $display("FAIL first_wins_result got=%h exp=%h", dut_r, e); end
  endtask

  task automatic test_straddle;
    exp_t e = '0;
    cycle(1, 39'h1000, 64'h8067_0001_0001_0001, m_v, 0, rdy_d, rdy_e);
    n_tests++;
    if ({scan_v_o, br_v_o, branch_o, jal_o, jalr_o, call_o, return_o, partial_o} !== 8'b1000_0001) begin
      n_fail++; $display("FAIL straddle_a got=%b exp=10000001",
        {scan_v_o, br_v_o, branch_o, jal_o, jalr_o, call_o, return_o, partial_o});
    end
    cycle(1, 39'h1008, 64'h0001_A001_0001_0000, 1, 0, rdy_d, rdy_e);
    e.br_v = 1; e.cls = 5'b00101; e.strad = 1; e.pc = 39'h1006;
    n_tests++; if (dut_r !== e) begin n_fail++; $display("FAIL straddle_b got=%h exp=%h", dut_r, e); end
  endtask

  task automatic test_calls;
    exp_t e = '0;
    cycle(1, 39'h3000, 64'h0001_0001_0001_9082, m_v, 0, rdy_d, rdy_e);
    e.br_v = 1; e.cls = 5'b00110; e.pc = 39'h3000;
    n_tests++; if (dut_r !== e) begin n_fail++; $display("FAIL cjalr_x1 got=%h exp=%h", dut_r, e); end
    cycle(1, 39'h3008, 64'h0001_0001_9282_0001, 1, 0, rdy_d, rdy_e);
    e.cls = 5'b00111; e.idx = 2'd1; e.pc = 39'h300A;
    n_tests++; if (dut_r !== e) begin n_fail++; $display("FAIL cjalr_x5 got=%h exp=%h", dut_r, e); end
  endtask

  task automatic test_back_to_back;
    exp_t e1 = '0, e2 = '0;
    cycle(1, 39'h4000, 64'h0001_0001_0001_C001, m_v, 0, rdy_d, rdy_e);
    e1.br_v = 1; e1.cls = 5'b10000; e1.pc = 39'h4000;
    for (int i = 0; i < 3; i++) begin
      cycle(1, 39'h4008, 64'hE001_0001_0001_0001, 0, 0, rdy_d, rdy_e);
      n_tests++; if (rdy_d !== 1'b0) begin n_fail++; $display("FAIL hold_ready[%0d] got=%b exp=0", i, rdy_d); end
      n_tests++; if ({scan_v_o, dut_r} !== {1'b1, e1}) begin n_fail++; $display("FAIL hold_stable[%0d] got=%b/%h exp=1/%h", i, scan_v_o, dut_r, e1); end
    end
    cycle(1, 39'h4008, 64'hE001_0001_0001_0001, 1, 0, rdy_d, rdy_e);
    e2.br_v = 1; e2.cls = 5'b10000; e2.idx = 2'd3; e2.pc = 39'h400E;
    n_tests++; if (rdy_d !== 1'b1) begin n_fail++; $display("FAIL b2b_ready got=%b exp=1", rdy_d); end
    n_tests++; if ({scan_v_o, dut_r} !== {1'b1, e2}) begin n_fail++; $display("FAIL b2b_result got=%b/%h exp=1/%h", scan_v_o, dut_r, e2); end
  endtask

  task automatic test_redirect;
    exp_t e = '0;
    cycle(1, 39'h1000, 64'h8067_0001_0001_0001, m_v, 0, rdy_d, rdy_e);
    cycle(1, 39'h1008, 64'h0001_0001_0001_0000, 1, 1, rdy_d, rdy_e);
    n_tests++; if (rdy_d !== 1'b0) begin n_fail++; $display("FAIL redirect_ready got=%b exp=0", rdy_d); end
    n_tests++; if (scan_v_o !== 1'b0) begin n_fail++; $display("FAIL redirect_drop got=%b exp=0", scan_v_o); end
    cycle(1, 39'h5000, 64'h0001_0001_8082_0000, 0, 0, rdy_d, rdy_e);
    e.br_v = 1; e.cls = 5'b00101; e.idx = 2'd1; e.pc = 39'h5002;
    n_tests++; if (dut_r !== e) begin n_fail++; $display("FAIL redirect_fresh got=%h exp=%h", dut_r, e); end
  endtask

  task automatic test_reset_mid;
    exp_t e = '0;
    cycle(1, 39'h1000, 64'h8067_0001_0001_0001, m_v, 0, rdy_d, rdy_e);
    #2 reset_i = 1;
    #1;
    n_tests++; if ({scan_v_o, dut_r} !== {1'b0, exp_t'(0)}) begin n_fail++; $display("FAIL reset_async got=%b/%h exp=0/0", scan_v_o, dut_r); end
    @(posedge clk); #1 reset_i = 0;
    m_v = 0; m_pend = 0;
    cycle(1, 39'h5000, 64'h0001_0001_8082_0000, 0, 0, rdy_d, rdy_e);
    e.br_v = 1; e.cls = 5'b00101; e.idx = 2'd1; e.pc = 39'h5002;
    n_tests++; if (dut_r !== e) begin n_fail++; $display("FAIL reset_clears_partial got=%h exp=%h", dut_r, e); end
  endtask

  task automatic test_random;
    logic [15:0] pool [20] = '{16'h0001, 16'h0000, 16'hA001, 16'hC001, 16'hE001, 16'h8082,
                               16'h8282, 16'h8102, 16'h9082, 16'h9282, 16'h9102, 16'h8002,
                               16'h9002, 16'h8086, 16'h00EF, 16'h006F, 16'h8067, 16'h80E7,
                               16'h0063, 16'h02E7};
    logic [VW-1:0] pc = 39'h100;
    logic [63:0]   data;
    bit fv, yumi, redir;
    for (int i = 0; i < 600; i++) begin
      for (int k = 0; k < NP; k++)
        data[16*k +: 16] = ($urandom_range(0, 7) == 0) ? 16'($urandom) : pool[$urandom_range(0, 19)];
      fv    = $urandom_range(0, 3) != 0;
      yumi  = m_v && ($urandom_range(0, 2) != 0);
      redir = $urandom_range(0, 19) == 0;
      cycle(fv, pc, data, yumi, redir, rdy_d, rdy_e);
      n_tests++; if (rdy_d !== rdy_e) begin n_fail++; $display("FAIL rand_ready[%0d] got=%b exp=%b", i, rdy_d, rdy_e); end
      if (redir) begin
        pc = ($urandom_range(0, 3) == 0) ? 39'h7F_FFFF_FFF8 : VW'({$urandom, $urandom});
        pc[0] = 1'b0;
      end else if (fv && rdy_e) begin
        pc = pc + VW'(2*NP);
      end
      n_tests++; if (scan_v_o !== m_v) begin n_fail++; $display("FAIL rand_scan_v[%0d] got=%b exp=%b", i, scan_v_o, m_v); end
      if (m_v) begin
        n_tests++;
        if (msk(dut_r, m_res.br_v) !== msk(m_res, m_res.br_v)) begin
          n_fail++; $display("FAIL rand_result[%0d] got=%h exp=%h", i, msk(dut_r, m_res.br_v), msk(m_res, m_res.br_v));
        end
      end
    end
  endtask

  initial begin
    test_reset;
    test_jal;
    test_first_wins;
    test_straddle;
    test_calls;
    test_back_to_back;
    test_redirect;
    test_reset_mid;
    test_random;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/bp_fe_scan_block.md
Name: bp_fe_scan_block

Overview:
- Multi-parcel successor to the single-instruction FE scanner. Scans a whole fetch block of fetch_parcels_p 16-bit parcels per cycle.
- Finds the first control-flow instruction in the block and classifies it.
- Carries a 32-bit instruction that straddles two fetch blocks, using a registered partial-parcel state.
- Sits between the I$ fetch output and the FE branch-prediction/redirect logic. Output is registered, with a valid/yumi handshake.

Parameters:
- fetch_parcels_p, 4, 16-bit parcels per fetch block; legal values 2, 4, 8.
- compressed_support_p, 1, enables RVC decode and parcel-granular alignment.
- vaddr_width_p, 39, virtual PC width.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  asynchronous, active-high reset.
- redirect_i  in  1  FE redirect; flushes partial and output state.
- fetch_v_i  in  1  fetch block valid.
- fetch_ready_o  out  1  block accepted when fetch_v_i & fetch_ready_o.
- fetch_pc_i  in  vaddr_width_p  PC of parcel 0.
- fetch_data_i  in  16*fetch_parcels_p  parcels; parcel k is at bits [16k+:16].
- scan_v_o  out  1  scan result valid.
- scan_yumi_i  in  1  consumer takes the result; legal only while scan_v_o=1.
- br_v_o  out  1  block contains a control-flow instruction.
- branch_o, jal_o, jalr_o, call_o, return_o  out  1 each  classification of the first control-flow instruction.
- br_idx_o  out  $clog2(fetch_parcels_p)  starting parcel of that instruction.
- br_straddle_o  out  1  that instruction began in the previous block.
- br_pc_o  out  vaddr_width_p  PC of that instruction.
- partial_o  out  1  block ended with the lower half of a 32-bit instruction.

Behaviour:
- Reset (async): scan_v_o, partial_r and all result outputs go to 0 immediately.
- fetch_ready_o = ~redirect_i & (~scan_v_o | scan_yumi_i).
- Latency: an accepted block's result appears on scan_v_o the next cycle. It is held stable until yumi. Accept and yumi in the same cycle give back-to-back results with no bubble.
- Parcel walk, decoding instruction boundaries left to right:
  - If partial_r=1, parcel 0 is the upper half of a 32-bit instruction formed as {parcel0, partial_lo_r}. Its PC is fetch_pc_i-2.
  - Otherwise the walk starts at parcel 0.
  - A parcel with bits[1:0]=2'b11 starts a 32-bit instruction covering 2 parcels; any other parcel is a 16-bit instruction.
  - compressed_support_p=0: instructions start at even parcels only; partial_r never sets.
- Classification, per instruction:
  - branch: BRANCH, C.BEQZ or C.BNEZ.
  - jal: JAL or C.J.
  - jalr: JALR, C.JR or C.JALR.
  - link(r) is true when r is x1 or x5.
  - call: JAL/JALR with link(rd), or C.JALR (rd=x1 implied).
  - return: JALR with link(rs1) & ~(link(rd) & rd==rs1); C.JR with link(rs1); C.JALR with link(rs1) & rs1!=x1.
  - Consequences: C.JALR x1 is a call only; C.JALR x5 is call and return.
- Result selection:
  - The first classified instruction in walk order wins; later ones are ignored.
  - br_v_o = any classified instruction.
  - br_idx_o is 0 when br_straddle_o=1.
  - br_pc_o = fetch_pc_i + 2*br_idx_o, or fetch_pc_i-2 when straddled.
  - When br_v_o=0, the classification fields are 0.
- Straddle:
  - If a 32-bit instruction starts at parcel N-1, the block sets partial_o=1, partial_r<=1 and partial_lo_r<=parcel N-1. It is not classified in that block.
  - partial_r updates only on accept; otherwise it holds.
  - The accepted block after a straddle is assumed to be sequential; redirect_i guarantees this.
  - A control-flow instruction that straddles still wins over later instructions in the next block.
- Redirect:
  - In cycle t, redirect_i forces fetch_ready_o=0. The input is not accepted.
  - At t+1, partial_r=0 and scan_v_o=0. Any pending result is dropped even if scan_yumi_i was high at t.
  - Redirect overrides everything except reset.
- PC arithmetic is modulo 2^vaddr_width_p.

Test Plan:
- N=4, pc=0x80000000, parcels {0x0001, 0xA001, 0x0001, 0x0001} -> next cycle scan_v_o=1, br_v_o=1, jal_o=1, br_idx_o=1, br_pc_o=0x80000002.
- Parcels {0x00EF, 0x0000, 0x8082, 0x0001} (JAL ra then C.JR ra) -> jal_o=1, call_o=1, return_o=0, br_idx_o=0; the C.JR is ignored.
- Block A {0x0001, 0x0001, 0x0001, 0x8067} at 0x1000 -> br_v_o=0, partial_o=1. Block B {0x0000, 0x0001, 0xA001, 0x0001} at 0x1008 -> jalr_o=1, return_o=1, br_straddle_o=1, br_pc_o=0x1006.
- C.JALR x1 (0x9082) -> call_o=1, return_o=0. C.JALR x5 (0x9282) -> call_o=1, return_o=1.
- Hold scan_yumi_i=0 for 3 cycles -> outputs stable, fetch_ready_o=0. Then yumi together with fetch_v_i -> new result the next cycle, no bubble.
- Straddle pending, then redirect_i pulse, then block {0x0000, ...} -> parcel 0 decoded fresh, br_straddle_o=0. Assert reset_i mid-transfer -> scan_v_o=0 immediately.
